// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the MEM-stage access unit: bus FSM encoding,
// default sizing constants and the local/external address decode.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } bus_state_t;

    localparam int DEFAULT_LOCAL_WORDS = 128;
    localparam int DEFAULT_TIMEOUT     = 255;

    function automatic logic is_local(
        input logic [31:0] addr,
        input logic [31:0] local_words = 32'(DEFAULT_LOCAL_WORDS)
    );
        return addr < local_words;
    endfunction

endpackage

// File: rtl/mem_bus_fsm.sv
// External bus sequencer: launches one access per request, waits for
// completion or timeout, and tracks pipeline flushes during the access.
module mem_bus_fsm
    import cpu_mem_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ext,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_flush,
    input  logic        bus_done,
    input  logic [31:0] bus_q,
    output bus_state_t  state,
    output logic        bus_start,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;
    logic          flush_pend;
    logic          flush_now;

    // A flush arriving in the same cycle as completion still discards the data.
    assign flush_now = flush_pend | cpu_flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            bus_start  <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_rdata  <= '0;
            bus_err    <= 1'b0;
            flush_pend <= 1'b0;
            count      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    flush_pend <= 1'b0;
                    if (ext) begin
                        bus_addr  <= cpu_addr;
                        bus_we    <= cpu_we;
                        bus_wdata <= cpu_wdata;
                        bus_start <= 1'b1;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    bus_start  <= 1'b0;
                    count      <= '0;
                    flush_pend <= flush_now;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus_done) begin
                        if (!bus_we && !flush_now) begin
                            bus_rdata <= bus_q;
                        end
                        flush_pend <= 1'b0;
                        state      <= flush_now ? ST_IDLE : ST_RESP;
                    end else if (count == LAST_COUNT) begin
                        bus_rdata  <= '0;
                        bus_err    <= 1'b1;
                        flush_pend <= 1'b0;
                        state      <= flush_now ? ST_IDLE : ST_RESP;
                    end else begin
                        count      <= count + 1'b1;
                        flush_pend <= flush_now;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data access initiator: local memory accesses complete in one
// cycle, everything else goes through the stalling external bus sequencer.
module mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int LOCAL_WORDS = DEFAULT_LOCAL_WORDS,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_flush,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    output logic        bus_err,
    output logic [31:0] dm_addr,
    output logic        dm_we,
    output logic [31:0] dm_data,
    output logic        dm_clear,
    output logic        dm_hold,
    input  logic [31:0] dm_q,
    output logic        bus_start,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_q,
    input  logic        bus_done
);

    bus_state_t  state;
    logic        ext;
    logic        local_acc;
    logic        rd_src;
    logic [31:0] bus_rdata;

    assign ext       = cpu_req && !is_local(cpu_addr, 32'(LOCAL_WORDS));
    assign local_acc = cpu_req && !ext;

    // Stall and memory writes are held off while reset is asserted.
    assign cpu_stall = reset_n && ((state == ST_IDLE && ext) ||
                                   state == ST_START || state == ST_WAIT);

    assign dm_addr  = cpu_addr;
    assign dm_data  = cpu_wdata;
    assign dm_we    = reset_n && local_acc && cpu_we && !cpu_stall;
    assign dm_hold  = cpu_stall;
    assign dm_clear = cpu_flush;

    mem_bus_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_fsm (
        .clk       (clk),
        .reset_n   (reset_n),
        .ext       (ext),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_flush (cpu_flush),
        .bus_done  (bus_done),
        .bus_q     (bus_q),
        .state     (state),
        .bus_start (bus_start),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_err   (bus_err)
    );

    // WB selects the bus result only for the cycle after an external retirement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_src <= 1'b0;
        end else if (!cpu_stall) begin
            rd_src <= (state == ST_RESP);
        end
    end

    assign cpu_rdata = rd_src ? bus_rdata : dm_q;

endmodule
